// File: rtl/ff_seq_pkg.sv
// Shared types and timing defaults for the flop-bank power-up / soft-reset sequencer.
package ff_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    CLR_REL,
    EN_ON,
    RUN,
    EN_OFF,
    CLR_ON
  } seq_state_e;

  localparam int CLR_HOLD_DEF  = 8;
  localparam int STAGE_GAP_DEF = 2;

  // Width of the shared wait counter: it must hold the longer of the two waits.
  function automatic int cnt_width(input int clr_hold, input int stage_gap);
    int longest;
    longest = (clr_hold > stage_gap) ? clr_hold : stage_gap;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/ff_bank_sequencer_if.sv
// Control/status bundle of ff_bank_sequencer; stage_gate exists only when
// SEQ_STAGE_GATE_EN is defined.
interface ff_bank_sequencer_if #(
  parameter int NUM_STAGES = 4
);

  logic                  soft_req;
  logic                  soft_ack;
  logic [NUM_STAGES-1:0] cd;
  logic [NUM_STAGES-1:0] sp;
  logic                  ready;
  logic                  busy;
`ifdef SEQ_STAGE_GATE_EN
  logic [NUM_STAGES-1:0] stage_gate;

  modport master (output soft_req, output stage_gate,
                  input soft_ack, input cd, input sp, input ready, input busy);
  modport slave  (input soft_req, input stage_gate,
                  output soft_ack, output cd, output sp, output ready, output busy);
`else
  modport master (output soft_req,
                  input soft_ack, input cd, input sp, input ready, input busy);
  modport slave  (input soft_req,
                  output soft_ack, output cd, output sp, output ready, output busy);
`endif

endinterface

// File: rtl/ff_seq_gap_timer.sv
// Loadable down-counter; done is high while the count is zero, i.e. on the edge
// that ends a wait of (load_val + 1) edges counted from the loading edge.
module ff_seq_gap_timer #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ff_bank_sequencer.sv
// Sequences per-bank clear (cd) and enable (sp) downstream-first on power-up and
// reverse-order on soft reset. Optional zero-latency RUN gating: SEQ_STAGE_GATE_EN.
module ff_bank_sequencer
  import ff_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int CLR_HOLD   = CLR_HOLD_DEF,
  parameter int STAGE_GAP  = STAGE_GAP_DEF
) (
  input logic               clk,
  input logic               resetn,
  ff_bank_sequencer_if.slave bus
);

  localparam int                    CW        = cnt_width(CLR_HOLD, STAGE_GAP);
  localparam int                    IW        = $clog2(NUM_STAGES) + 1;
  localparam logic [CW-1:0]         HOLD_LOAD = CW'(CLR_HOLD - 1);
  localparam logic [CW-1:0]         GAP_LOAD  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_ONES  = '1;

  seq_state_e            state, state_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [NUM_STAGES-1:0] cd_q, cd_nx;
  logic [NUM_STAGES-1:0] sp_q, sp_nx;
  logic                  ready_q, ready_nx;
  logic                  busy_q;
  logic                  ack_q, ack_nx;
  logic                  soft_q;
  logic                  pending, pending_nx;
  logic                  soft_rise;
  logic                  tmr_load, tmr_done;
  logic [CW-1:0]         tmr_val;

  assign soft_rise = bus.soft_req & ~soft_q;

  // Reset value equals the CLR_HOLD reload, so reset behaves like a CLR_ON edge.
  ff_seq_gap_timer #(
    .W       (CW),
    .RST_VAL (HOLD_LOAD)
  ) u_gap_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= HOLD;
      idx     <= '0;
      cd_q    <= ALL_ONES;
      sp_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      soft_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state   <= state_nx;
      idx     <= idx_nx;
      cd_q    <= cd_nx;
      sp_q    <= sp_nx;
      ready_q <= ready_nx;
      busy_q  <= ~ready_nx;
      ack_q   <= ack_nx;
      soft_q  <= bus.soft_req;
      pending <= pending_nx;
    end
  end

  always_comb begin
    // NOTE: everything defaulted first so no branch can infer a latch.
    state_nx   = state;
    idx_nx     = idx;
    cd_nx      = cd_q;
    sp_nx      = sp_q;
    ready_nx   = ready_q;
    ack_nx     = 1'b0;
    pending_nx = pending | soft_rise;
    tmr_load   = 1'b0;
    tmr_val    = GAP_LOAD;

    unique case (state)
      HOLD: if (tmr_done) begin
        cd_nx[0] = 1'b0;
        tmr_load = 1'b1;
        if (NUM_STAGES == 1) begin
          state_nx = EN_ON;
          idx_nx   = '0;
        end else begin
          state_nx = CLR_REL;
          idx_nx   = IW'(1);
        end
      end

      CLR_REL: if (tmr_done) begin
        for (int i = 0; i < NUM_STAGES; i++)
          if (idx == IW'(i)) cd_nx[i] = 1'b0;
        tmr_load = 1'b1;
        if (idx == LAST_IDX) begin
          state_nx = EN_ON;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end

      EN_ON: if (tmr_done) begin
        for (int i = 0; i < NUM_STAGES; i++)
          if (idx == IW'(i)) sp_nx[i] = 1'b1;
        tmr_load = 1'b1;
        if (idx == LAST_IDX) begin
          ready_nx = 1'b1;
          state_nx = RUN;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end

      // A request seen on this very edge is honoured without waiting for pending.
      RUN: if (pending | soft_rise) begin
        pending_nx = 1'b0;
        ready_nx   = 1'b0;
        state_nx   = EN_OFF;
        idx_nx     = LAST_IDX;
        tmr_load   = 1'b1;
      end

      EN_OFF: if (tmr_done) begin
        for (int i = 0; i < NUM_STAGES; i++)
          if (idx == IW'(i)) sp_nx[i] = 1'b0;
        tmr_load = 1'b1;
        if (idx == '0) state_nx = CLR_ON;
        else           idx_nx   = idx - 1'b1;
      end

      CLR_ON: if (tmr_done) begin
        cd_nx    = ALL_ONES;
        ack_nx   = 1'b1;
        state_nx = HOLD;
        idx_nx   = '0;
        tmr_load = 1'b1;
        tmr_val  = HOLD_LOAD;
      end

      default: state_nx = HOLD;
    endcase
  end

  assign bus.cd       = cd_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.soft_ack = ack_q;

`ifdef SEQ_STAGE_GATE_EN
  // The gate acts only in RUN, where the register already holds all ones.
  assign bus.sp = (state == RUN) ? (sp_q & bus.stage_gate) : sp_q;
`else
  assign bus.sp = sp_q;
`endif

endmodule

// File: tb/tb_ff_bank_sequencer.sv
// Self-checking bench: timeline model of the default 4-stage sequencer plus
// literal expectations for the default and a 1-stage/1-cycle configuration.
module tb_ff_bank_sequencer;

  localparam int N  = 4;
  localparam int CH = 8;
  localparam int G  = 2;
  localparam int T_READY = CH + (2 * N - 1) * G;
  localparam int T_ACK   = (N + 1) * G;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  int total = 0;
  int bad   = 0;

  ff_bank_sequencer_if #(.NUM_STAGES(N)) bus ();
  ff_bank_sequencer_if #(.NUM_STAGES(1)) bus1 ();

  ff_bank_sequencer #(.NUM_STAGES(N), .CLR_HOLD(CH), .STAGE_GAP(G)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  ff_bank_sequencer #(.NUM_STAGES(1), .CLR_HOLD(1), .STAGE_GAP(1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: each sequence starts at edge m_s; a shutdown starts at edge m_k.
  int          edge_n = 0;
  int          m_s    = 0;
  int          m_k    = -1;
  bit          m_pend = 1'b0;
  bit          m_prev = 1'b0;
  bit          m_ack  = 1'b0;
  logic [N-1:0] x_cd  = '1;
  logic [N-1:0] x_sp  = '0;
  logic         x_ready = 1'b0;

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      edge_n = 0; m_s = 0; m_k = -1; m_pend = 1'b0; m_prev = 1'b0; m_ack = 1'b0;
    end else begin
      edge_n++;
      m_ack = 1'b0;
      if (bus.soft_req && !m_prev) m_pend = 1'b1;
      m_prev = bus.soft_req;
      if (m_k < 0 && m_pend && edge_n > m_s + T_READY) begin
        m_k = edge_n;
        m_pend = 1'b0;
      end else if (m_k >= 0 && edge_n == m_k + T_ACK) begin
        m_s = edge_n;
        m_k = -1;
        m_ack = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_k < 0) begin
        x_cd[i] = (edge_n - m_s) < CH + i * G;
        x_sp[i] = (edge_n - m_s) >= CH + (N + i) * G;
      end else begin
        x_cd[i] = 1'b0;
        x_sp[i] = edge_n < m_k + (N - i) * G;
      end
    end
    x_ready = (m_k < 0) && (edge_n - m_s >= T_READY);
  end

  always @(negedge clk) begin
    logic [N-1:0] sp_exp;
    sp_exp = x_sp;
`ifdef SEQ_STAGE_GATE_EN
    if (x_ready) sp_exp = x_sp & bus.stage_gate;
`endif
    check("model_cd",    32'(bus.cd),    32'(x_cd));
    check("model_sp",    32'(bus.sp),    32'(sp_exp));
    check("model_ready", 32'(bus.ready), 32'(x_ready));
    check("model_busy",  32'(bus.busy),  32'(!x_ready));
    check("model_ack",   32'(bus.soft_ack), 32'(m_ack));
    check("inv_sp_cd",   32'(bus.sp & bus.cd), 32'd0);
    check("inv_ack_rdy", 32'(bus.soft_ack & bus.ready), 32'd0);
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_n < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n != n) check($sformatf("edge_wait_%0d", n), 32'(edge_n), 32'(n));
  endtask

  task automatic check_main(input string tag, input logic [3:0] cd, input logic [3:0] sp,
                            input logic rdy, input logic ack);
    check({"cd@", tag},    32'(bus.cd),       32'(cd));
    check({"sp@", tag},    32'(bus.sp),       32'(sp));
    check({"ready@", tag}, 32'(bus.ready),    32'(rdy));
    check({"busy@", tag},  32'(bus.busy),     32'(!rdy));
    check({"ack@", tag},   32'(bus.soft_ack), 32'(ack));
  endtask

  task automatic exp_main(input int e, input logic [3:0] cd, input logic [3:0] sp,
                          input logic rdy, input logic ack);
    wait_edge(e);
    check_main($sformatf("e%0d", e), cd, sp, rdy, ack);
  endtask

  task automatic exp_one(input int e, input logic cd, input logic sp,
                         input logic rdy, input logic ack);
    string tag;
    wait_edge(e);
    tag = $sformatf("n1_e%0d", e);
    check({"cd@", tag},    32'(bus1.cd),       32'(cd));
    check({"sp@", tag},    32'(bus1.sp),       32'(sp));
    check({"ready@", tag}, 32'(bus1.ready),    32'(rdy));
    check({"busy@", tag},  32'(bus1.busy),     32'(!rdy));
    check({"ack@", tag},   32'(bus1.soft_ack), 32'(ack));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    bus.soft_req  = 1'b0;
    bus1.soft_req = 1'b0;
`ifdef SEQ_STAGE_GATE_EN
    bus.stage_gate  = '1;
    bus1.stage_gate = '1;
`endif
    @(negedge clk);
    check_main("reset", 4'hF, 4'h0, 1'b0, 1'b0);
    #2 resetn = 1'b1;

    // Power-up of both instances; 1-stage instance does a soft cycle early.
    exp_one(1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_main(1, 4'hF, 4'h0, 1'b0, 1'b0);
    exp_one(2, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_edge(3);
    bus1.soft_req = 1'b1;
    exp_one(4, 1'b0, 1'b1, 1'b0, 1'b0);
    bus1.soft_req = 1'b0;
    exp_one(5, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_one(6, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_one(7, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_main(7, 4'hF, 4'h0, 1'b0, 1'b0);
    exp_one(8, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_main(8,  4'hE, 4'h0, 1'b0, 1'b0);
    exp_main(10, 4'hC, 4'h0, 1'b0, 1'b0);
    exp_main(12, 4'h8, 4'h0, 1'b0, 1'b0);
    exp_main(14, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_main(16, 4'h0, 4'h1, 1'b0, 1'b0);
    exp_main(18, 4'h0, 4'h3, 1'b0, 1'b0);
    exp_main(20, 4'h0, 4'h7, 1'b0, 1'b0);
    exp_main(21, 4'h0, 4'h7, 1'b0, 1'b0);
    exp_main(22, 4'h0, 4'hF, 1'b1, 1'b0);
`ifdef SEQ_STAGE_GATE_EN
    wait_edge(24);
    #1 bus.stage_gate = 4'b0101;
    exp_main(25, 4'h0, 4'b0101, 1'b1, 1'b0);
    #1 bus.stage_gate = '1;
`endif
    wait_edge(29);
    bus.soft_req = 1'b1;
    exp_main(30, 4'h0, 4'hF, 1'b0, 1'b0);
    bus.soft_req = 1'b0;
    exp_main(32, 4'h0, 4'h7, 1'b0, 1'b0);
    exp_main(34, 4'h0, 4'h3, 1'b0, 1'b0);
    exp_main(36, 4'h0, 4'h1, 1'b0, 1'b0);
    exp_main(38, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_main(40, 4'hF, 4'h0, 1'b0, 1'b1);
    exp_main(41, 4'hF, 4'h0, 1'b0, 1'b0);
    exp_main(61, 4'h0, 4'h7, 1'b0, 1'b0);
    exp_main(62, 4'h0, 4'hF, 1'b1, 1'b0);

    // Request captured during CLR_REL, level then held high.
    do_reset();
    wait_edge(11);
    bus.soft_req = 1'b1;
    exp_main(22, 4'h0, 4'hF, 1'b1, 1'b0);
    exp_main(23, 4'h0, 4'hF, 1'b0, 1'b0);
    exp_main(25, 4'h0, 4'h7, 1'b0, 1'b0);
    exp_main(31, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_main(33, 4'hF, 4'h0, 1'b0, 1'b1);
    exp_main(55, 4'h0, 4'hF, 1'b1, 1'b0);
    exp_main(60, 4'h0, 4'hF, 1'b1, 1'b0);
    bus.soft_req = 1'b0;

    // Asynchronous reset in the middle of EN_ON.
    do_reset();
    exp_main(17, 4'h0, 4'h1, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1 check_main("rst_mid", 4'hF, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 resetn = 1'b1;
    exp_main(8,  4'hE, 4'h0, 1'b0, 1'b0);
    exp_main(22, 4'h0, 4'hF, 1'b1, 1'b0);

    // Random requests, occasional resets and gate values against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) bus.soft_req = ~bus.soft_req;
      resetn = ($urandom_range(0, 699) != 0);
`ifdef SEQ_STAGE_GATE_EN
      if ($urandom_range(0, 3) == 0) bus.stage_gate = 4'($urandom_range(0, 15));
`endif
    end
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
